// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// counter_bank : button-driven bank of counters with selection and auto-repeat
// Revision     : 1.0
// ============================================================================
module counter_bank #(
  parameter int NUM_CNTRS     = 8,
  parameter int CNTR_WIDTH    = 16,
  parameter int WRAP_MODE     = 1,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  localparam int IDX_W        = $clog2(NUM_CNTRS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sel_in,
  input  logic                            inc_in,
  input  logic                            rev_in,
  input  logic                            clr_in,
  input  logic [NUM_CNTRS*CNTR_WIDTH-1:0] cntr_def,
  output logic [NUM_CNTRS*CNTR_WIDTH-1:0] cntrs,
  output logic [CNTR_WIDTH-1:0]           cntr_sel,
  output logic [IDX_W-1:0]                cntr_cur,
  output logic [NUM_CNTRS-1:0]            cntr_ind
);

  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]      C_HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]      C_REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);
  localparam logic [TMR_W-1:0]      C_TMR_ONE   = TMR_W'(1);
  localparam logic [IDX_W-1:0]      C_IDX_LAST  = IDX_W'(NUM_CNTRS - 1);
  localparam logic [IDX_W-1:0]      C_IDX_ONE   = IDX_W'(1);
  localparam logic [CNTR_WIDTH-1:0] C_CNT_ONE   = CNTR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_HOLD   = 2'd2,
    S_REPEAT = 2'd3
  } state_e;

  // Bit order in the synchroniser vectors: 0 sel, 1 inc, 2 clr, 3 rev.
  logic [3:0] sync1_q, sync2_q;
  logic [2:0] edge_q;

  state_e                 state_q;
  logic [TMR_W-1:0]       tmr_q;
  logic [IDX_W-1:0]       cur_q;
  logic [CNTR_WIDTH-1:0]  cnt_q [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0]  def_w [NUM_CNTRS];

  logic                   clr_ev, sel_ev, inc_ev;
  logic                   inc_s, rev_s;
  logic [CNTR_WIDTH-1:0]  cur_val;
  logic [CNTR_WIDTH-1:0]  step_d;
  logic [IDX_W-1:0]       cur_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= {rev_in, clr_in, inc_in, sel_in};
      sync2_q <= sync1_q;
      edge_q  <= sync2_q[2:0];
    end
  end

  assign inc_s  = sync2_q[1];
  assign rev_s  = sync2_q[3];
  assign clr_ev = sync2_q[2] & ~edge_q[2];
  assign sel_ev = sync2_q[0] & ~edge_q[0] & ~clr_ev;
  assign inc_ev = sync2_q[1] & ~edge_q[1] & ~clr_ev & ~sel_ev;

  assign cur_val = cnt_q[cur_q];

  // Saturation only blocks the step that would cross the range limit.
  always_comb begin
    step_d = cur_val;
    if (rev_s) begin
      if ((cur_val != '0) || (WRAP_MODE != 0)) step_d = cur_val - C_CNT_ONE;
    end else begin
      if ((cur_val != '1) || (WRAP_MODE != 0)) step_d = cur_val + C_CNT_ONE;
    end
  end

  always_comb begin
    cur_d = cur_q;
    if (rev_s) cur_d = (cur_q == '0) ? C_IDX_LAST : cur_q - C_IDX_ONE;
    else       cur_d = (cur_q == C_IDX_LAST) ? '0 : cur_q + C_IDX_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      tmr_q   <= '0;
      cur_q   <= '0;
      for (int i = 0; i < NUM_CNTRS; i++) cnt_q[i] <= '0;
    end else if (state_q == S_INIT) begin
      for (int i = 0; i < NUM_CNTRS; i++) cnt_q[i] <= def_w[i];
      state_q <= S_IDLE;
    end else if (clr_ev) begin
      cnt_q[cur_q] <= def_w[cur_q];
      tmr_q        <= '0;
      state_q      <= S_IDLE;
    end else if (sel_ev) begin
      cur_q   <= cur_d;
      tmr_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inc_ev) begin
            cnt_q[cur_q] <= step_d;
            tmr_q        <= '0;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!inc_s) begin
            state_q <= S_IDLE;
          end else if (tmr_q == C_HOLD_LAST) begin
            cnt_q[cur_q] <= step_d;
            tmr_q        <= '0;
            state_q      <= S_REPEAT;
          end else begin
            tmr_q <= tmr_q + C_TMR_ONE;
          end
        end
        S_REPEAT: begin
          if (!inc_s) begin
            state_q <= S_IDLE;
          end else if (tmr_q == C_REP_LAST) begin
            cnt_q[cur_q] <= step_d;
            tmr_q        <= '0;
          end else begin
            tmr_q <= tmr_q + C_TMR_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CNTRS; g++) begin : g_pack
    assign def_w[g]                             = cntr_def[g*CNTR_WIDTH +: CNTR_WIDTH];
    assign cntrs[g*CNTR_WIDTH +: CNTR_WIDTH]    = cnt_q[g];
    assign cntr_ind[g]                          = (cur_q == IDX_W'(g));
  end

  assign cntr_sel = cur_val;
  assign cntr_cur = cur_q;

endmodule
`default_nettype wire

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter NUM_CNTRS, default 8: number of counters; legal range 2..16, not limited to powers of two.
REQ-002 Parameter CNTR_WIDTH, default 16: bit width of each counter.
REQ-003 Parameter WRAP_MODE, default 1: 1 = modular wrap on overflow/underflow, 0 = saturate at 0 and 2^CNTR_WIDTH-1.
REQ-004 Parameter HOLD_CYCLES, default 25000000: clk cycles inc_in must stay held before auto-repeat starts.
REQ-005 Parameter REPEAT_CYCLES, default 5000000: clk cycles between auto-repeat steps.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 sel_in  input  1  button level, asynchronous to clk; rising edge moves the selection.
REQ-009 inc_in  input  1  button level, asynchronous; rising edge steps the selected counter; holding it auto-repeats.
REQ-010 rev_in  input  1  level, asynchronous; 1 = decrement and select downward.
REQ-011 clr_in  input  1  button level, asynchronous; rising edge reloads the selected counter with its default.
REQ-012 cntr_def  input  NUM_CNTRS*CNTR_WIDTH  packed defaults; counter i at bits [i*CNTR_WIDTH +: CNTR_WIDTH].
REQ-013 cntrs  output  NUM_CNTRS*CNTR_WIDTH  packed counter values, same packing as cntr_def.
REQ-014 cntr_sel  output  CNTR_WIDTH  value of the currently selected counter.
REQ-015 cntr_cur  output  clog2(NUM_CNTRS)  index of the selected counter.
REQ-016 cntr_ind  output  NUM_CNTRS  one-hot selection indicator; bit cntr_cur = 1.

Function
REQ-017 sel_in, inc_in, rev_in, clr_in shall each pass through a 2-flop synchroniser; edges shall be detected on the synchronised signal against a third register.
REQ-018 A rising edge on a synchronised input shall produce exactly one event pulse lasting one clk cycle; the resulting update shall be visible on outputs 3 clk edges after the first edge that samples the input high.
REQ-019 FSM states: INIT, IDLE, HOLD, REPEAT.
REQ-020 INIT: entered on reset; on the first clk edge after rst_n deasserts, all counters shall load cntr_def and the FSM shall go to IDLE.
REQ-021 IDLE: an inc event shall step the selected counter once and go to HOLD with the hold timer cleared.
REQ-022 HOLD: if synchronised inc is still 1 after HOLD_CYCLES cycles, the FSM shall step once and go to REPEAT; if inc drops, it shall return to IDLE.
REQ-023 REPEAT: one step every REPEAT_CYCLES cycles while synchronised inc = 1; return to IDLE when inc = 0.
REQ-024 Step direction shall be sampled from synchronised rev in the same cycle as the step: +1 if rev = 0, -1 if rev = 1.
REQ-025 WRAP_MODE=1: arithmetic modulo 2^CNTR_WIDTH. WRAP_MODE=0: increment at max and decrement at 0 shall leave the value unchanged.
REQ-026 A sel event shall set cntr_cur to (cntr_cur+1) mod NUM_CNTRS, or to (cntr_cur-1) mod NUM_CNTRS when rev = 1. Example: NUM_CNTRS=5, 4 -> 0 and 0 -> 4.
REQ-027 Simultaneous events in one cycle: priority clr > sel > inc; lower-priority events that cycle shall be discarded.
REQ-028 A clr or sel event while in HOLD/REPEAT shall abort auto-repeat and return to IDLE; a new inc edge is required to step again.
REQ-029 Only the selected counter shall change on any event; cntr_def changes shall have no effect except at INIT or on clr.
REQ-030 cntr_sel and cntr_ind shall be combinational from cntr_cur and the counter registers.

Reset
REQ-031 rst_n = 0 shall immediately force: all counters 0, cntr_cur 0, cntr_ind = 1, FSM INIT, synchroniser/edge/timer registers 0.
REQ-032 Reset asserted mid-repeat shall abort without a further step; after release, counters shall hold cntr_def values.

Verification (NUM_CNTRS=5, CNTR_WIDTH=8, HOLD_CYCLES=4, REPEAT_CYCLES=2)
REQ-033 Release reset with defaults {10,20,30,40,50} -> cntrs = defaults after 1 clk; cntr_cur = 0, cntr_ind = 5'b00001.
REQ-034 Pulse inc_in for 2 clks -> counter0 = 11 exactly 3 clks after the first sample; no further change.
REQ-035 Hold inc_in 12 clks -> one step, then the 2nd step at HOLD_CYCLES, then one step per 2 clks; counter0 shall total 10 + 1 + 1 + floor(remaining/2).
REQ-036 WRAP_MODE=0, counter at 255, inc -> 255; rev = 1, counter at 0, inc -> 0. WRAP_MODE=1: 255 -> 0 and 0 -> 255.
REQ-037 rev = 1, sel from cntr_cur 0 -> 4, cntr_ind = 5'b10000; then clr and inc edges in the same cycle -> counter4 = 50 with no step.
REQ-038 Assert rst_n low during REPEAT -> outputs 0 immediately; after release, defaults reloaded and FSM in IDLE.
